fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer for the async FIFO, in the rd_clk domain. Pops DATA_WIDTH words from the
//  FIFO's first-word-fall-through read port (dout valid whenever !empty, rd_en pops) and packs
//  RATIO words LSB-first into one DATA_WIDTH*RATIO word. Presents the packed word on a registered
//  valid/ready master stream. Sustains one FIFO pop per cycle while the output keeps up.
// PARAMETERS
//  DATA_WIDTH  8   FIFO word width; must equal the FIFO's DATA_WIDTH
//  RATIO       4   FIFO words per output word; >=2
//  TIMEOUT     16  idle rd_clk cycles before a partial flush (used only with FLUSH_TIMEOUT_EN); >=1
// PORTS
//  rd_clk      in   1                 read-domain clock (single clock of this block)
//  rst_n       in   1                 asynchronous active-low reset
//  fifo_empty  in   1                 FIFO empty flag
//  fifo_dout   in   DATA_WIDTH        FIFO read data (FWFT)
//  fifo_rd_en  out  1                 FIFO pop strobe
//  m_valid     out  1                 packed word valid
//  m_ready     in   1                 downstream accept
//  m_data      out  DATA_WIDTH*RATIO  packed word; FIFO word k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//  m_keep      out  RATIO             1 per valid lane
// BEHAVIOUR
//  - Reset (async, immediate): fifo_rd_en=0, m_valid=0, m_data='0, m_keep='0, acc_cnt=0,
//    acc='0, idle timer=0. Reset mid-operation discards any partial and held word, with no flush.
//  - Accumulator FSM:
//    - ACC_EMPTY (acc_cnt==0) -> ACC_PART on a pop.
//    - ACC_PART (1..RATIO-1 stored) -> ACC_EMPTY on the completing pop or on a flush.
//  - Output register FSM:
//    - OUT_EMPTY -> OUT_FULL on load.
//    - OUT_FULL -> OUT_EMPTY on m_valid&m_ready with no same-cycle load.
//  - out_free = !m_valid | m_ready.
//  - fifo_rd_en = !fifo_empty & ((acc_cnt != RATIO-1) | out_free). Combinational, never asserted
//    when fifo_empty=1.
//  - Pop with acc_cnt<RATIO-1: lane acc_cnt <= fifo_dout; acc_cnt++.
//  - Completing pop (acc_cnt==RATIO-1, out_free): in the same edge, m_data <= {fifo_dout, acc lanes};
//    m_keep <= all ones; m_valid <= 1; acc_cnt <= 0.
//  - Latency: m_valid rises on the rd_clk edge that pops the RATIO-th word.
//  - Simultaneous drain and load (m_valid&m_ready and a completing pop): m_valid stays 1 and new data
//    loads, so there are no bubbles.
//  - m_data and m_keep are stable while m_valid&!m_ready (AXI-style hold). m_valid never drops without
//    a handshake.
//  - Output stalled with acc_cnt==RATIO-1: no pop occurs and FIFO words stay queued (backpressure).
//  - acc_cnt width is clogb2(RATIO-1)+1 and it wraps to 0 only by explicit load or flush, never by
//    overflow.
//  - fifo_empty toggling mid-pack: the accumulator simply waits; there is no timeout without the macro.
// CONFIGURATION
//  - FLUSH_TIMEOUT_EN defined:
//    - The idle timer counts cycles with acc_cnt>0 and no pop, and clears on any pop or at
//      acc_cnt==0.
//    - At timer==TIMEOUT-1 with out_free: load a partial word. Lanes <acc_cnt hold data, the rest are
//      0. m_keep = (1<<acc_cnt)-1. acc_cnt <= 0. The timer clears.
//    - If the output is not free, the flush waits. A pop arriving in that cycle cancels the flush.
//  - FLUSH_TIMEOUT_EN undefined: no timer logic. m_keep is all ones on every valid word (0 at reset).
//    Partial words are held indefinitely.
// STRUCTURE
//  - Shared package fifo_pkg: clogb2 function, TCO delay constant, typedef enum acc_state_t
//    {ACC_EMPTY, ACC_PART}, typedef enum out_state_t {OUT_EMPTY, OUT_FULL}. This block and the
//    async FIFO both import fifo_pkg.
//  - No sub-module: the accumulator, output register and timer stay inline in one module.
// TESTING
//  - Fill: FIFO holds 0x11,0x22,0x33,0x44; m_ready=1 -> after 4 pops m_data=0x44332211,
//    m_keep=4'hF, m_valid high for 1 cycle.
//  - Streaming: 8 words 0x01..0x08 back-to-back; m_ready=1 -> fifo_rd_en high for 8 consecutive
//    cycles; outputs 0x04030201 then 0x08070605.
//  - Backpressure: 8 words queued, m_ready=0 -> first word held stable; fifo_rd_en stops after 7 pops
//    (acc_cnt=3). Raise m_ready -> second word loads on the accept edge with no bubble.
//  - Empty gap: 0xAA,0xBB, then fifo_empty=1 for 10 cycles, then 0xCC,0xDD -> m_data=0xDDCCBBAA;
//    fifo_rd_en never high while fifo_empty=1.
//  - Reset mid-pack: 2 words popped, pulse rst_n low -> m_valid=0, acc cleared immediately. The next
//    4 words form a clean packed word.
//  - FLUSH_TIMEOUT_EN, TIMEOUT=16: 0x5A,0xA5 then idle -> 16 cycles later m_data=0x0000A55A,
//    m_keep=4'b0011.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side consumers.
package fifo_pkg;

  localparam int unsigned TCO = 1;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_PART  = 1'b1
  } acc_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Ceiling log2; clogb2(1) == 0.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops FWFT FIFO words and packs RATIO of them LSB-first into one output word.
// Optional partial flush after TIMEOUT idle cycles when FLUSH_TIMEOUT_EN is defined.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          rd_clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  output logic                          fifo_rd_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH*RATIO-1:0]   m_data,
  output logic [RATIO-1:0]              m_keep
);

  localparam int unsigned PW = DATA_WIDTH * RATIO;
  localparam int unsigned AW = DATA_WIDTH * (RATIO - 1);
  localparam int unsigned CW = clogb2(RATIO - 1) + 1;

  if (RATIO < 2) begin : g_bad_ratio
    $error("fifo_rd_packer: RATIO must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_rd_packer: TIMEOUT must be >= 1");
  end

  acc_state_t       acc_q, acc_d;
  out_state_t       out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    lanes_q, lanes_d;
  logic [PW-1:0]    data_d;
  logic [RATIO-1:0] keep_d;
  logic             out_free;
  logic             last;
  logic             pop;
  logic             complete;
  logic             load;
  logic             flush;

  assign m_valid    = (out_q == OUT_FULL);
  assign out_free   = !m_valid || m_ready;
  assign last       = (cnt_q == CW'(RATIO - 1));
  // The final lane may only be popped when the output register can take the packed word.
  assign fifo_rd_en = rst_n && !fifo_empty && (!last || out_free);
  assign pop        = fifo_rd_en;
  assign complete   = pop && last;

`ifdef FLUSH_TIMEOUT_EN
  localparam int unsigned TW = clogb2(TIMEOUT) + 1;

  logic [TW-1:0] timer_q, timer_d;

  // Idle timer: counts non-popping cycles while a partial word is held.
  always_comb begin
    timer_d = timer_q;
    flush   = 1'b0;
    if (pop || acc_q == ACC_EMPTY) begin
      timer_d = '0;
    end else if (timer_q == TW'(TIMEOUT - 1)) begin
      if (out_free) begin
        flush   = 1'b1;
        timer_d = '0;
      end
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign flush = 1'b0;
`endif

  // Accumulator and output register next-state.
  always_comb begin
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    data_d  = m_data;
    keep_d  = m_keep;
    load    = 1'b0;

    if (pop && !last) begin
      for (int k = 0; k < int'(RATIO) - 1; k++) begin
        if (cnt_q == CW'(k)) begin
          lanes_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
        end
      end
      cnt_d = cnt_q + CW'(1);
    end

    if (complete) begin
      data_d = {fifo_dout, lanes_q};
      keep_d = '1;
      cnt_d  = '0;
      load   = 1'b1;
    end

    // Partial flush: lanes at or above the fill level are zeroed, stale lane data is never exposed.
    if (flush) begin
      data_d = '0;
      keep_d = '0;
      for (int k = 0; k < int'(RATIO) - 1; k++) begin
        if (int'(cnt_q) > k) begin
          data_d[k*DATA_WIDTH +: DATA_WIDTH] = lanes_q[k*DATA_WIDTH +: DATA_WIDTH];
          keep_d[k] = 1'b1;
        end
      end
      cnt_d = '0;
      load  = 1'b1;
    end

    case (acc_q)
      ACC_EMPTY: if (pop)                acc_d = ACC_PART;
      ACC_PART:  if (complete || flush)  acc_d = ACC_EMPTY;
      default:                           acc_d = ACC_EMPTY;
    endcase

    case (out_q)
      OUT_EMPTY: if (load)               out_d = OUT_FULL;
      OUT_FULL:  if (m_ready && !load)   out_d = OUT_EMPTY;
      default:                           out_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= ACC_EMPTY;
      out_q   <= OUT_EMPTY;
      cnt_q   <= '0;
      lanes_q <= '0;
      m_data  <= '0;
      m_keep  <= '0;
    end else begin
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      m_data  <= data_d;
      m_keep  <= keep_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based FWFT FIFO model.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned TO = 16;

  logic            rd_clk;
  logic            rst_n;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_rd_en;
  logic            m_valid;
  logic            m_ready;
  logic [DW*R-1:0] m_data;
  logic [R-1:0]    m_keep;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  logic          last_pop;
  logic          last_empty;

  fifo_rd_packer #(.DATA_WIDTH(DW), .RATIO(R), .TIMEOUT(TO)) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    drive_fifo();
  endtask

  // One clock: sample the pop strobe mid-cycle, pop the model on the edge, settle outputs.
  task automatic tick();
    @(negedge rd_clk);
    last_pop   = fifo_rd_en;
    last_empty = fifo_empty;
    @(posedge rd_clk);
    #(TCO);
    if (last_pop && q.size() != 0) q.delete(0);
    drive_fifo();
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", m_valid); end
    vectors++;
    if (m_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h, expected 00000000", m_data); end
    vectors++;
    if (m_keep !== 4'h0) begin miscompares++; $display("FAIL reset_keep: got %h, expected 0", m_keep); end
    push(8'h99);
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b, expected 0", fifo_rd_en); end
    q.delete();
    drive_fifo();
    @(posedge rd_clk);
    @(posedge rd_clk);
    #(TCO);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (last_pop !== 1'b1) begin miscompares++; $display("FAIL fill_pop%0d: got %b, expected 1", i, last_pop); end
      if (i == 2) begin
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL fill_early_valid: got %b, expected 0", m_valid); end
      end
    end
    vectors++;
    if (m_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid: got %b, expected 1", m_valid); end
    vectors++;
    if (m_data !== 32'h44332211) begin miscompares++; $display("FAIL fill_data: got %h, expected 44332211", m_data); end
    vectors++;
    if (m_keep !== 4'hF) begin miscompares++; $display("FAIL fill_keep: got %h, expected f", m_keep); end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL fill_drain: got %b, expected 0", m_valid); end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int w = 1; w <= 8; w++) push(8'(w));
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (last_pop !== 1'b1) begin miscompares++; $display("FAIL stream_pop%0d: got %b, expected 1", i, last_pop); end
      if (i == 3) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201) begin
          miscompares++; $display("FAIL stream_word0: got valid=%b data=%h, expected valid=1 data=04030201", m_valid, m_data);
        end
      end
      if (i == 4) begin
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL stream_gap: got %b, expected 0", m_valid); end
      end
      if (i == 7) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h08070605) begin
          miscompares++; $display("FAIL stream_word1: got valid=%b data=%h, expected valid=1 data=08070605", m_valid, m_data);
        end
      end
    end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got %b, expected 0", m_valid); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int w = 1; w <= 8; w++) push(8'(w));
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++;
      if (last_pop !== 1'b1) begin miscompares++; $display("FAIL bp_pop%0d: got %b, expected 1", i, last_pop); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (last_pop !== 1'b0) begin miscompares++; $display("FAIL bp_stall_pop%0d: got %b, expected 0", i, last_pop); end
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'hF) begin
        miscompares++; $display("FAIL bp_hold%0d: got valid=%b data=%h keep=%h, expected valid=1 data=04030201 keep=f", i, m_valid, m_data, m_keep);
      end
    end
    vectors++;
    if (q.size() != 1) begin miscompares++; $display("FAIL bp_queued: got %0d, expected 1", q.size()); end
    m_ready = 1'b1;
    tick();
    vectors++;
    if (last_pop !== 1'b1) begin miscompares++; $display("FAIL bp_release_pop: got %b, expected 1", last_pop); end
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'h08070605) begin
      miscompares++; $display("FAIL bp_no_bubble: got valid=%b data=%h, expected valid=1 data=08070605", m_valid, m_data);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b, expected 0", m_valid); end
  endtask

  task automatic test_empty_gap();
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (last_empty !== 1'b1 || last_pop !== 1'b0) begin
        miscompares++; $display("FAIL gap_rd_en%0d: got empty=%b rd_en=%b, expected empty=1 rd_en=0", i, last_empty, last_pop);
      end
    end
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL gap_valid: got %b, expected 0", m_valid); end
    push(8'hCC); push(8'hDD);
    tick(); tick();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'hDDCCBBAA || m_keep !== 4'hF) begin
      miscompares++; $display("FAIL gap_word: got valid=%b data=%h keep=%h, expected valid=1 data=ddccbbaa keep=f", m_valid, m_data, m_keep);
    end
    tick();
  endtask

  task automatic test_reset_midpack();
    m_ready = 1'b0;
    for (int w = 1; w <= 6; w++) push(8'(w));
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (m_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_valid: got %b, expected 1", m_valid); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_keep !== 4'h0) begin
      miscompares++; $display("FAIL rmid_clear: got valid=%b data=%h keep=%h, expected all 0", m_valid, m_data, m_keep);
    end
    tick(); tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'hE4E3E2E1 || m_keep !== 4'hF) begin
      miscompares++; $display("FAIL rmid_word: got valid=%b data=%h keep=%h, expected valid=1 data=e4e3e2e1 keep=f", m_valid, m_data, m_keep);
    end
    tick();
  endtask

`ifdef FLUSH_TIMEOUT_EN
  task automatic test_flush();
    m_ready = 1'b1;
    push(8'h5A); push(8'hA5);
    tick(); tick();
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL flush_early: got %b, expected 0", m_valid); end
    tick();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 32'h0000A55A || m_keep !== 4'b0011) begin
      miscompares++; $display("FAIL flush_word: got valid=%b data=%h keep=%b, expected valid=1 data=0000a55a keep=0011", m_valid, m_data, m_keep);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drain: got %b, expected 0", m_valid); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    m_ready    = 1'b0;
    last_pop   = 1'b0;
    last_empty = 1'b1;
    drive_fifo();
    test_reset();
    test_fill();
    test_stream();
    test_backpressure();
    test_empty_gap();
    test_reset_midpack();
`ifdef FLUSH_TIMEOUT_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
